// File: rtl/ecp5pll_phase_ctrl_if.sv
// ecp5pll_phase_ctrl_if
// Request and status bundle between user logic and the phase-shift sequencer.
//   req_valid/req_ready : request handshake (transfer when both high)
//   req_load            : 1 = phaseloadreg request, 0 = step request
//   req_sel             : clk_o index to shift (0..3)
//   req_dir             : 0 = later (lag), 1 = earlier
//   req_steps           : number of phasestep pulses
//   busy/done/err       : sequencer status (done one-cycle pulse, err sticky)
// master = requester, slave = sequencer.
interface ecp5pll_phase_ctrl_if #(
    parameter int STEPS_W = 8
);
    logic               req_valid;
    logic               req_ready;
    logic               req_load;
    logic [1:0]         req_sel;
    logic               req_dir;
    logic [STEPS_W-1:0] req_steps;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output req_valid, req_load, req_sel, req_dir, req_steps,
        input  req_ready, busy, done, err
    );

    modport slave (
        input  req_valid, req_load, req_sel, req_dir, req_steps,
        output req_ready, busy, done, err
    );
endinterface

// File: rtl/ecp5pll_phase_ctrl.sv
// ecp5pll_phase_ctrl
// Sequencer for the ECP5 PLL dynamic phase-shift port. Takes "shift output N by
// K fine steps" or "load phase" requests, drives phasesel/phasedir, issues
// registered phasestep/phaseloadreg strobes with fixed setup/high/gap times,
// then waits for PLL lock and reports done (pulse) or err (sticky timeout).
// Ports:
//   clk_i, reset           : clock, asynchronous active-high reset
//   req (slave modport)    : request handshake and busy/done/err status
//   phasesel, phasedir     : held from accept to the next accept
//   phasestep, phaseloadreg: strobes to ecp5pll
//   locked                 : ecp5pll lock, asynchronous, synchronized inside
module ecp5pll_phase_ctrl #(
    parameter int SETUP_CYCLES = 4,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int STEPS_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 reset,
    ecp5pll_phase_ctrl_if.slave  req,
    output logic [1:0]           phasesel,
    output logic                 phasedir,
    output logic                 phasestep,
    output logic                 phaseloadreg,
    input  logic                 locked
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETUP     = 3'd1;
    localparam logic [2:0] PULSE     = 3'd2;
    localparam logic [2:0] GAP       = 3'd3;
    localparam logic [2:0] LOAD      = 3'd4;
    localparam logic [2:0] WAIT_LOCK = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    localparam int TMR_MAX0 = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int TMR_MAX  = (TMR_MAX0 > GAP_CYCLES) ? TMR_MAX0 : GAP_CYCLES;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int WAIT_W   = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    logic [2:0]         state_reg, state_next;
    logic [TMR_W-1:0]   tmr_reg, tmr_next;
    logic [STEPS_W-1:0] remaining_reg, remaining_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic               err_reg, err_next;
    logic               load_reg;
    logic [1:0]         sel_reg;
    logic               dir_reg;
    logic               step_reg, loadreg_reg, done_reg;
    logic               lock_meta_reg, lock_s_reg;
    logic               accept;

    assign accept = req.req_valid && (state_reg == IDLE);

    always_comb begin
        state_next     = state_reg;
        tmr_next       = tmr_reg + 1'b1;
        remaining_next = remaining_reg;
        wait_next      = wait_reg;
        err_next       = err_reg;
        case (state_reg)
            IDLE: begin
                tmr_next  = '0;
                wait_next = '0;
                if (accept) begin
                    state_next     = SETUP;
                    remaining_next = req.req_steps;
                    err_next       = 1'b0;
                end
            end
            SETUP: begin
                if (tmr_reg == TMR_W'(SETUP_CYCLES - 1)) begin
                    tmr_next = '0;
                    if (load_reg)
                        state_next = LOAD;
                    else if (remaining_reg == '0)
                        state_next = DONE;
                    else
                        state_next = PULSE;
                end
            end
            PULSE: begin
                if (tmr_reg == TMR_W'(PULSE_CYCLES - 1)) begin
                    tmr_next       = '0;
                    remaining_next = remaining_reg - 1'b1;
                    state_next     = GAP;
                end
            end
            GAP: begin
                if (tmr_reg == TMR_W'(GAP_CYCLES - 1)) begin
                    tmr_next   = '0;
                    wait_next  = '0;
                    state_next = (remaining_reg != '0) ? PULSE : WAIT_LOCK;
                end
            end
            LOAD: begin
                if (tmr_reg == TMR_W'(PULSE_CYCLES - 1)) begin
                    tmr_next       = '0;
                    remaining_next = '0;
                    state_next     = GAP;
                end
            end
            WAIT_LOCK: begin
                tmr_next  = '0;
                wait_next = wait_reg + 1'b1;
                // The first two cycles are blanked: lock_s only reflects
                // locked sampled after the last strobe once it has crossed
                // both synchronizer flops, so earlier values may be stale.
                if ((32'(wait_reg) >= 2) && lock_s_reg) begin
                    state_next = DONE;
                end else if (wait_reg == WAIT_W'(LOCK_TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: begin
                tmr_next   = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            tmr_reg       <= '0;
            remaining_reg <= '0;
            wait_reg      <= '0;
            err_reg       <= 1'b0;
            load_reg      <= 1'b0;
            sel_reg       <= 2'd0;
            dir_reg       <= 1'b0;
            step_reg      <= 1'b0;
            loadreg_reg   <= 1'b0;
            done_reg      <= 1'b0;
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= locked;
            lock_s_reg    <= lock_meta_reg;
            state_reg     <= state_next;
            tmr_reg       <= tmr_next;
            remaining_reg <= remaining_next;
            wait_reg      <= wait_next;
            err_reg       <= err_next;
            if (accept) begin
                load_reg <= req.req_load;
                sel_reg  <= req.req_sel;
                dir_reg  <= req.req_dir;
            end
            // Strobes are decoded from the next state so they are flops that
            // line up exactly with the PULSE/LOAD states.
            step_reg    <= (state_next == PULSE);
            loadreg_reg <= (state_next == LOAD);
            done_reg    <= (state_reg == DONE);
        end
    end

    assign phasesel      = sel_reg;
    assign phasedir      = dir_reg;
    assign phasestep     = step_reg;
    assign phaseloadreg  = loadreg_reg;
    assign req.req_ready = (state_reg == IDLE);
    assign req.busy      = (state_reg != IDLE);
    assign req.done      = done_reg;
    assign req.err       = err_reg;
endmodule
